// File: rtl/iob2axi_wr_ctrl.sv
// Burst scheduler for iob2axi_wr: splits one write command into AXI INCR bursts
// (max 2^`AXI_LEN_W beats, no 4 KB crossing). Optional abort/drain: IOB2AXI_WR_CTRL_ABORT_EN.
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif

module iob2axi_wr_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [CNT_W-1:0]        cmd_len,
    output logic                    cmd_ready,
    output logic                    done,
    output logic                    error,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [DATA_W/8-1:0]     in_strb,
    output logic                    in_ready,
    output logic                    eng_valid,
    output logic [ADDR_W-1:0]       eng_addr,
    output logic [`AXI_LEN_W-1:0]   eng_length,
    output logic [DATA_W-1:0]       eng_wdata,
    output logic [DATA_W/8-1:0]     eng_wstrb,
    input  logic                    eng_sready,
    input  logic                    eng_ready,
    input  logic                    eng_error
);
    localparam int unsigned NB        = DATA_W / 8;
    localparam int unsigned OFF_W     = $clog2(NB);
    localparam int unsigned LEN_W     = `AXI_LEN_W;
    localparam int unsigned BW        = CNT_W + 1;
    localparam int unsigned MAX_BURST = 1 << LEN_W;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ISSUE,
        DATA,
        RESP
`ifdef IOB2AXI_WR_CTRL_ABORT_EN
        , DRAIN
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [BW-1:0]      beats_q, beats_d;
    logic [BW-1:0]      bcnt_q, bcnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               error_q, error_d;
    logic               done_q, done_d;

    // Burst size: smallest of remaining beats, max AXI burst, and room left in the 4 KB page
    logic [12:0]        page_room_c;
    logic [BW-1:0]      room_beats_c, lim_c, rem_ext_c, beats_c;
    logic [ADDR_W-1:0]  incr_c;

    assign page_room_c  = 13'(4096) - {1'b0, addr_q[11:0]};
    assign room_beats_c = BW'(page_room_c >> OFF_W);
    assign lim_c        = BW'(MAX_BURST);
    assign rem_ext_c    = BW'(rem_q);
    assign beats_c      = (rem_ext_c < lim_c)
                          ? ((rem_ext_c < room_beats_c) ? rem_ext_c : room_beats_c)
                          : ((lim_c < room_beats_c) ? lim_c : room_beats_c);
    assign incr_c       = ADDR_W'(beats_q) << OFF_W;

    assign eng_addr   = addr_q;
    assign eng_length = len_q;
    assign eng_wdata  = in_data;
    assign eng_wstrb  = in_strb;
    assign done       = done_q;
    assign error      = error_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            beats_q <= '0;
            bcnt_q  <= '0;
            len_q   <= '0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            beats_q <= beats_d;
            bcnt_q  <= bcnt_d;
            len_q   <= len_d;
            error_q <= error_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        beats_d   = beats_q;
        bcnt_d    = bcnt_q;
        len_d     = len_q;
        error_d   = error_q;
        done_d    = 1'b0;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        eng_valid = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr & ~ADDR_W'(NB - 1);
                    rem_d   = cmd_len;
                    error_d = 1'b0;
                    if (cmd_len == '0) done_d = 1'b1;
                    else               state_d = CALC;
                end
            end
            CALC: begin
                beats_d = beats_c;
                bcnt_d  = beats_c;
                len_d   = LEN_W'(beats_c - BW'(1));
                state_d = ISSUE;
            end
            ISSUE: begin
                eng_valid = 1'b1;
                if (eng_ready) state_d = DATA;
            end
            DATA: begin
                eng_valid = in_valid;
                in_ready  = eng_sready;
                if (in_valid && eng_sready) begin
                    bcnt_d = bcnt_q - BW'(1);
                    rem_d  = rem_q - CNT_W'(1);
                    if (bcnt_q == BW'(1)) state_d = RESP;
                end
            end
            RESP: begin
                // eng_valid stays low here so the engine cannot restart before we move on
                if (eng_ready) begin
                    error_d = error_q | eng_error;
                    addr_d  = addr_q + incr_c;
                    if (rem_q == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
`ifdef IOB2AXI_WR_CTRL_ABORT_EN
                    else if (eng_error) begin
                        state_d = DRAIN;
                    end
`endif
                    else begin
                        state_d = CALC;
                    end
                end
            end
`ifdef IOB2AXI_WR_CTRL_ABORT_EN
            DRAIN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end
endmodule
